// File: rtl/calendar_pkg.sv
// Shared calendar definitions for the date counter.
//   - Field widths for day-of-month and month, and the top year offset.
//   - Month constants JAN..DEC.
//   - days_in_month(): month length given the month and a leap-year flag.
package calendar_pkg;

    localparam int DATE_W   = 5;
    localparam int MONTH_W  = 4;
    localparam int YEAR_MAX = 99;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    // Month length. Anything that is not Feb or a 30-day month reports 31;
    // callers only ever present legal months, so that default is harmless.
    function automatic logic [DATE_W-1:0] days_in_month(
        input logic [MONTH_W-1:0] m,
        input logic               leap
    );
        logic [DATE_W-1:0] d;
        d = 5'd31;
        case (m)
            FEB:               d = leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: d = 5'd30;
            default:           d = 5'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/month_length.sv
// Combinational month-length lookup.
// Ports:
//   month - month number 1..12
//   year  - year offset from 2000 (0..99); divisible by 4 means leap,
//           which is exact across 2000..2099
//   days  - number of days in that month (28..31)
module month_length
    import calendar_pkg::*;
#(
    parameter int YEAR_W = 7
) (
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DATE_W-1:0]  days
);

    logic leap;

    assign leap = ((year % YEAR_W'(4)) == '0);
    assign days = days_in_month(month, leap);

endmodule

// File: rtl/date_calendar.sv
// Calendar date counter (day-of-month, month, year offset 0..99 = 2000..2099).
// Advances one day per hourCount (midnight carry), supports a sanitised
// parallel load, and issues registered month/year rollover pulses.
// Ports:
//   clk        - system clock
//   clear      - synchronous active-high reset to RESET_DATE/MONTH/YEAR
//   load       - load data_date/data_month/data_year (sanitised) this cycle
//   data_*     - load values
//   hourCount  - one-cycle midnight carry, advances the date by one day
//   enable     - gates databus
//   date/month/year - current calendar state
//   databus    - {year,month,date} when enable, else zero (combinational)
//   monthCount - one-cycle pulse alongside the first day of a new month
//   yearCount  - one-cycle pulse alongside Jan 1 of a new year
module date_calendar
    import calendar_pkg::*;
#(
    parameter int YEAR_W      = 7,
    parameter int RESET_DATE  = 1,
    parameter int RESET_MONTH = 1,
    parameter int RESET_YEAR  = 0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATE_W-1:0]     data_date,
    input  logic [MONTH_W-1:0]    data_month,
    input  logic [YEAR_W-1:0]     data_year,
    input  logic                  hourCount,
    input  logic                  enable,
    output logic [DATE_W-1:0]     date,
    output logic [MONTH_W-1:0]    month,
    output logic [YEAR_W-1:0]     year,
    output logic [9+YEAR_W-1:0]   databus,
    output logic                  monthCount,
    output logic                  yearCount
);

    localparam int BUS_W = 9 + YEAR_W;
    localparam logic [YEAR_W-1:0] YEAR_TOP = YEAR_W'(YEAR_MAX);

    logic [DATE_W-1:0]  date_reg,  date_next;
    logic [MONTH_W-1:0] month_reg, month_next;
    logic [YEAR_W-1:0]  year_reg,  year_next;
    logic               month_pulse_reg, month_pulse_next;
    logic               year_pulse_reg,  year_pulse_next;

    // Length of the current month, for the advance path.
    logic [DATE_W-1:0]  cur_days;
    // Sanitised load values and the length of the month being loaded.
    logic [MONTH_W-1:0] load_month;
    logic [YEAR_W-1:0]  load_year;
    logic [DATE_W-1:0]  load_days;
    logic [DATE_W-1:0]  load_date;

    logic last_day;
    logic last_month;
    logic last_year;

    month_length #(.YEAR_W(YEAR_W)) u_cur_len (
        .month (month_reg),
        .year  (year_reg),
        .days  (cur_days)
    );

    month_length #(.YEAR_W(YEAR_W)) u_load_len (
        .month (load_month),
        .year  (load_year),
        .days  (load_days)
    );

    // Load sanitisation: month and year are fixed first, then the date is
    // clamped against the length of the resulting month, so e.g. 31/2 in a
    // non-leap year lands on the 28th.
    always_comb begin
        load_month = data_month;
        if (data_month == '0 || data_month > DEC)
            load_month = JAN;

        load_year = data_year;
        if (data_year > YEAR_TOP)
            load_year = YEAR_TOP;

        load_date = data_date;
        if (data_date == '0)
            load_date = 5'd1;
        else if (data_date > load_days)
            load_date = load_days;
    end

    // ">=" rather than "==" keeps the counter self-correcting should the
    // state ever be out of range.
    assign last_day   = (date_reg >= cur_days);
    assign last_month = (month_reg >= DEC);
    assign last_year  = (year_reg >= YEAR_TOP);

    always_comb begin
        date_next        = date_reg;
        month_next       = month_reg;
        year_next        = year_reg;
        month_pulse_next = 1'b0;
        year_pulse_next  = 1'b0;

        if (load) begin
            date_next  = load_date;
            month_next = load_month;
            year_next  = load_year;
        end else if (hourCount) begin
            if (!last_day) begin
                date_next = date_reg + 5'd1;
            end else begin
                date_next        = 5'd1;
                month_pulse_next = 1'b1;
                if (!last_month) begin
                    month_next = month_reg + 4'd1;
                end else begin
                    month_next      = JAN;
                    year_pulse_next = 1'b1;
                    year_next       = last_year ? '0 : year_reg + YEAR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            date_reg        <= DATE_W'(RESET_DATE);
            month_reg       <= MONTH_W'(RESET_MONTH);
            year_reg        <= YEAR_W'(RESET_YEAR);
            month_pulse_reg <= 1'b0;
            year_pulse_reg  <= 1'b0;
        end else begin
            date_reg        <= date_next;
            month_reg       <= month_next;
            year_reg        <= year_next;
            month_pulse_reg <= month_pulse_next;
            year_pulse_reg  <= year_pulse_next;
        end
    end

    assign date       = date_reg;
    assign month      = month_reg;
    assign year       = year_reg;
    assign monthCount = month_pulse_reg;
    assign yearCount  = year_pulse_reg;

    logic [BUS_W-1:0] bus_raw;
    assign bus_raw = {year_reg, month_reg, date_reg};

    genvar gi;
    generate
        for (gi = 0; gi < BUS_W; gi++) begin : g_bus_gate
            assign databus[gi] = bus_raw[gi] & enable;
        end
    endgenerate

endmodule
